// File: rtl/temporal_encoder.sv
// Binary-to-temporal encoder: latches a NUM_CH value vector and replays each value as a spike time
// inside one gamma cycle. Define TEMPORAL_ENC_PULSE_EN for fixed-width pulses instead of held edges.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready=1
// RUN   | gamma cycle in progress, k=0..G-1, in_ready=0
// CLR   | one-cycle reset gap with all spikes low, in_ready=1
module temporal_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int NUM_CH            = 4,
  localparam int VAL_W            = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*VAL_W-1:0] in_val,
  input  logic [NUM_CH-1:0]       in_null,
  output logic [NUM_CH-1:0]       spike,
  output logic                    gamma_start,
  output logic                    gamma_last,
  output logic                    busy
);

  localparam int CW = $clog2(GAMMA_CYCLE_WIDTH);
  localparam logic [VAL_W-1:0] G_VAL  = VAL_W'(GAMMA_CYCLE_WIDTH);
  localparam logic [CW-1:0]    K_LAST = CW'(GAMMA_CYCLE_WIDTH - 1);

  if (GAMMA_CYCLE_WIDTH < 2 || PULSE_WIDTH < 1 || PULSE_WIDTH > GAMMA_CYCLE_WIDTH) begin : g_bad_param
    $error("temporal_encoder: illegal GAMMA_CYCLE_WIDTH / PULSE_WIDTH combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, CLR} state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          k, k_d;
  logic [NUM_CH*CW-1:0]   val_q, val_d;
  logic [NUM_CH-1:0]      inf_q, inf_d;
  logic                   load;
  logic [NUM_CH-1:0]      spike_d;
  logic                   gamma_start_d, gamma_last_d;

  always_comb begin
    state_d = state;
    k_d     = k;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
          k_d     = '0;
        end
      end
      RUN: begin
        if (k == K_LAST) begin
          state_d = CLR;
          k_d     = '0;
        end else begin
          k_d = k + 1'b1;
        end
      end
      CLR: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
          k_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range values are folded into the infinity flag at capture time.
  always_comb begin
    val_d = val_q;
    inf_d = inf_q;
    if (load) begin
      for (int i = 0; i < NUM_CH; i++) begin
        val_d[i*CW +: CW] = in_val[i*VAL_W +: CW];
        inf_d[i]          = in_null[i] | (in_val[i*VAL_W +: VAL_W] >= G_VAL);
      end
    end
  end

  // Outputs are registered, so they are decoded from next-state values.
  always_comb begin
    spike_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_d == RUN && !inf_d[i]) begin
`ifdef TEMPORAL_ENC_PULSE_EN
        spike_d[i] = (k_d >= val_d[i*CW +: CW]) &&
                     (32'(k_d) <= 32'(val_d[i*CW +: CW]) + 32'(PULSE_WIDTH - 1));
`else
        spike_d[i] = (k_d >= val_d[i*CW +: CW]);
`endif
      end
    end
    gamma_start_d = (state_d == RUN) && (k_d == '0);
    gamma_last_d  = (state_d == RUN) && (k_d == K_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      val_q       <= '0;
      inf_q       <= '0;
      spike       <= '0;
      gamma_start <= 1'b0;
      gamma_last  <= 1'b0;
    end else begin
      state       <= state_d;
      k           <= k_d;
      val_q       <= val_d;
      inf_q       <= inf_d;
      spike       <= spike_d;
      gamma_start <= gamma_start_d;
      gamma_last  <= gamma_last_d;
    end
  end

  assign in_ready = (state != RUN);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_temporal_encoder.sv
// Self-checking bench for temporal_encoder (edge mode, G=16, NUM_CH=4): fixed vector table,
// hand-written multi-cycle sequences, and randomized traffic against a phase-counting model.
module tb_temporal_encoder;
  localparam int G  = 16;
  localparam int NC = 4;
  localparam int VW = 5;

  logic            clk, rst_n, in_valid, in_ready;
  logic [NC*VW-1:0] in_val;
  logic [NC-1:0]   in_null, spike;
  logic            gamma_start, gamma_last, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: mk = -1 idle, 0..G-1 position in the gamma cycle, G = reset gap.
  int               mk = -1;
  logic [NC*VW-1:0] mval = '0;
  logic [NC-1:0]    mnull = '0;

  typedef struct packed {
    logic [NC*VW-1:0] val;
    logic [NC-1:0]    nul;
    logic [NC*VW-1:0] rise;   // per channel: first k with spike high, 16 = never
  } vec_t;
  vec_t tbl [4];

  temporal_encoder #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(8), .NUM_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_val(in_val), .in_null(in_null), .spike(spike),
    .gamma_start(gamma_start), .gamma_last(gamma_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mk = -1;
    else if ((mk < 0 || mk == G) && in_valid) begin
      mk = 0; mval = in_val; mnull = in_null;
    end else if (mk >= 0 && mk < G) mk = mk + 1;
    else mk = -1;
  end

  function automatic logic [NC-1:0] model_spike(int kk, logic [NC*VW-1:0] v, logic [NC-1:0] n);
    logic [NC-1:0] r;
    int val;
    r = '0;
    if (kk >= 0 && kk < G)
      for (int i = 0; i < NC; i++) begin
        val = int'(v[i*VW +: VW]);
        if (!n[i] && val < G && kk >= val) r[i] = 1'b1;
      end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_spike", 32'(spike), 32'(model_spike(mk, mval, mnull)));
    chk("model_gamma_start", 32'(gamma_start), 32'(mk == 0));
    chk("model_gamma_last", 32'(gamma_last), 32'(mk == G - 1));
    chk("model_busy", 32'(busy), 32'(mk >= 0));
    chk("model_in_ready", 32'(in_ready), 32'(mk < 0 || mk == G));
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check_model();
  endtask

  task automatic rand_vec();
    for (int i = 0; i < NC; i++) begin
      in_val[i*VW +: VW] = 5'($urandom_range(19, 0));
      in_null[i]         = ($urandom_range(4, 0) == 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] exp_sp;
    int starts, last, start0;
    bit found;

    tbl[0] = '{val: {5'd3, 5'd15, 5'd5, 5'd0},  nul: 4'b0000, rise: {5'd3, 5'd15, 5'd5, 5'd0}};
    tbl[1] = '{val: {5'd2, 5'd2, 5'd31, 5'd16}, nul: 4'b1000, rise: {5'd16, 5'd2, 5'd16, 5'd16}};
    tbl[2] = '{val: {5'd7, 5'd0, 5'd14, 5'd1},  nul: 4'b0101, rise: {5'd7, 5'd16, 5'd14, 5'd16}};
    tbl[3] = '{val: {5'd15, 5'd15, 5'd15, 5'd15}, nul: 4'b0000, rise: {5'd15, 5'd15, 5'd15, 5'd15}};

    rst_n = 1'b0; in_valid = 1'b0; in_val = '0; in_null = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_spike", 32'(spike), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);

    // Vector table: one gamma cycle each, with in_val scrambled after capture.
    for (int t = 0; t < 4; t++) begin
      in_val = tbl[t].val; in_null = tbl[t].nul; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_val = 20'($urandom); in_null = 4'($urandom);
      for (int k = 0; k <= G; k++) begin
        exp_sp = '0;
        if (k < G)
          for (int i = 0; i < NC; i++) exp_sp[i] = (k >= int'(tbl[t].rise[i*VW +: VW]));
        chk($sformatf("tbl%0d_spike_k%0d", t, k), 32'(spike), 32'(exp_sp));
        chk($sformatf("tbl%0d_gstart_k%0d", t, k), 32'(gamma_start), 32'(k == 0));
        chk($sformatf("tbl%0d_glast_k%0d", t, k), 32'(gamma_last), 32'(k == G - 1));
        tick();
      end
    end

    // Back-to-back: three vectors with in_valid held high.
    starts = 0; last = -1;
    rand_vec(); in_valid = 1'b1;
    for (int c = 0; c < 100 && starts < 3; c++) begin
      tick();
      if (gamma_start) begin
        if (last >= 0) chk("b2b_spacing", 32'(cyc - last), 32'd17);
        last = cyc; starts++;
        if (starts < 3) rand_vec();
        else in_valid = 1'b0;
      end
    end
    chk("b2b_starts", 32'(starts), 32'd3);
    in_valid = 1'b0;
    repeat (20) tick();

    // Backpressure: new vector offered at k=7, accepted in the CLR cycle.
    rand_vec(); in_valid = 1'b1;
    tick();
    start0 = cyc;
    in_valid = 1'b0;
    repeat (7) tick();
    rand_vec(); in_valid = 1'b1;
    chk("bp_ready_k7", 32'(in_ready), 32'd0);
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      tick();
      if (gamma_start) found = 1;
    end
    chk("bp_found", 32'(found), 32'd1);
    chk("bp_accept_delay", 32'(cyc - start0), 32'd17);
    in_valid = 1'b0;
    repeat (20) tick();

    // Asynchronous reset in the middle of a gamma cycle with all spikes high.
    in_val = '0; in_null = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("rst_pre_spike", 32'(spike), 32'hf);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_spike", 32'(spike), 32'd0);
    chk("rst_async_gstart", 32'(gamma_start), 32'd0);
    chk("rst_async_glast", 32'(gamma_last), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_ready", 32'(in_ready), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("rst_quiet_spike", 32'(spike), 32'd0);
      chk("rst_quiet_busy", 32'(busy), 32'd0);
    end

    // Randomized traffic; inputs change every cycle, model checks each cycle.
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(2, 0) != 0);
      rand_vec();
      tick();
    end
    in_valid = 1'b0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/temporal_encoder.md
# temporal_encoder

Binary-to-temporal encoder for the race-logic datapath. It accepts a vector of NUM_CH binary values through a valid/ready handshake and replays them as spike times inside one gamma cycle of GAMMA_CYCLE_WIDTH clocks. Each channel's spike time equals its value. It drives the temporal operators (min, max, less-than-eq, inhibition) at the input of each column, and is the transmit end of the temporal-code interface those operators consume.

## Interface
- GAMMA_CYCLE_WIDTH, 16: clocks per gamma cycle (G); legal range is G ≥ 2.
- PULSE_WIDTH, 8: spike width in clocks; used only when TEMPORAL_ENC_PULSE_EN is defined; legal range is 1 ≤ PULSE_WIDTH ≤ G.
- NUM_CH, 4: number of independent channels.
- VAL_W (localparam): $clog2(GAMMA_CYCLE_WIDTH)+1.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  value vector present.
- in_ready  out  1  block can accept a vector this cycle.
- in_val  in  NUM_CH*VAL_W  channel i occupies bits [i*VAL_W +: VAL_W]; the value is unsigned.
- in_null  in  NUM_CH  1 means the channel emits no spike in this gamma cycle (infinity).
- spike  out  NUM_CH  registered temporal-coded outputs.
- gamma_start  out  1  registered; 1-cycle pulse on the first RUN cycle.
- gamma_last  out  1  registered; 1-cycle pulse on the last RUN cycle.
- busy  out  1  high in RUN and CLR.

## Operation
- FSM states: IDLE, RUN, CLR.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready, latch in_val/in_null into the value registers, clear the counter k to 0, and go to RUN.
- RUN
  - Lasts exactly G cycles, k=0..G-1.
  - gamma_start=1 at k=0; gamma_last=1 at k=G-1.
  - Moves to CLR after k=G-1.
  - in_ready=0.
- CLR
  - Lasts 1 cycle; all spike outputs are 0; this is the temporal-logic reset gap that operator latches require.
  - in_ready=1; a handshake in CLR goes directly to RUN, otherwise the FSM goes to IDLE.
- Channel effective value v_i is infinity if in_null[i]=1 or in_val_i ≥ G; otherwise v_i = in_val_i.
- Edge mode (default): spike[i]=1 during RUN cycle k iff k ≥ v_i. The rising edge is the event, and it is held to the end of RUN.
- Spikes are 0 in IDLE and CLR; a channel with v_i=infinity stays 0 for the whole gamma cycle.
- Values are captured only at the handshake; changes on in_val during RUN are ignored.
- The counter is $clog2(G) bits and never wraps inside RUN; terminal detection is k==G-1.

## Timing
- Reset values: spike=0, gamma_start=0, gamma_last=0, busy=0, in_ready=1, state=IDLE, k=0.
- in_ready and busy are combinational decodes of the state register.
- Latency: handshake at clock edge n gives first RUN cycle n+1. A channel with v_i=0 drives spike high in that same cycle, coincident with gamma_start.
- Throughput: back-to-back vectors (in_valid held high) give one gamma cycle every G+1 clocks.
- Reset asserted mid-RUN forces all outputs to reset values immediately (asynchronously). After release, the block is in IDLE with no residual spikes.
- in_valid high during RUN causes no acceptance; the upstream holds the vector until the IDLE/CLR handshake.

## Configuration
- TEMPORAL_ENC_PULSE_EN defined: pulse mode. spike[i]=1 iff v_i ≤ k ≤ v_i+PULSE_WIDTH-1, clipped at k=G-1; a pulse never crosses into CLR.
- TEMPORAL_ENC_PULSE_EN undefined: edge mode as above; the PULSE_WIDTH parameter is present but unused.
- FSM, handshake and gamma_start/gamma_last timing are identical in both modes.

## Test plan
All scenarios use G=16, NUM_CH=4.

- Reset: rst_n=0 mid-RUN with spike=4'b1111 → all outputs 0 within the same cycle, in_ready=1; after release the state is IDLE and spike stays 0 for 20 cycles.
- Edge mode, vals {0,5,15,3}, null=0 → gamma_start coincides with spike[0] rising; spike[3] rises at k=3, spike[1] at k=5, spike[2] at k=15; all fall in CLR; gamma_last at k=15.
- Infinity handling: vals {16,31,2,2}, null=4'b1000 → spike[0], spike[1] and spike[3] stay 0 all cycle; spike[2] rises at k=2.
- Back-to-back: in_valid held high with 3 vectors → gamma_start pulses exactly 17 clocks apart; each CLR cycle has spike=0; no vector is dropped or duplicated.
- Backpressure: new in_val applied at k=7 with in_valid=1 → in_ready=0, outputs are unchanged, and the vector is accepted in the CLR cycle.
- Pulse mode (TEMPORAL_ENC_PULSE_EN, PULSE_WIDTH=8), vals {0,4,12,15} → spike[0] high k=0..7; spike[1] high k=4..11; spike[2] high k=12..15 (clipped); spike[3] high at k=15 only.
